modem_ctrl: RTL and testbench



---
 rtl/modem_ctrl.sv | 73 +++++++
 tb/tb_modem_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/modem_ctrl.sv
// Modem control/status: drives RTS/DTR pads, synchronises CTS/DSR/RI/DCD,
// keeps the MSR image with sticky deltas, interrupt and internal loopback.
module modem_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       mcr_dtr,
  input  logic       mcr_rts,
  input  logic       mcr_out1,
  input  logic       mcr_out2,
  input  logic       mcr_loop,
  input  logic       ms_int_en,
  input  logic       msr_rd,
  input  logic       cts_pad_i,
  input  logic       dsr_pad_i,
  input  logic       ri_pad_i,
  input  logic       dcd_pad_i,
  output logic       rts_pad_o,
  output logic       dtr_pad_o,
  output logic [7:0] msr,
  output logic       ms_int
);

  logic [3:0] pads;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] cur;
  logic [3:0] prev;
  logic [3:0] delta;
  logic [3:0] set;

  assign pads = {dcd_pad_i, ri_pad_i, dsr_pad_i, cts_pad_i};

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pads;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  // Loopback feeds the MCR bits straight in, bypassing the synchroniser
  assign cur = mcr_loop ?
    {mcr_out2, mcr_out1, mcr_dtr, mcr_rts} :
    sync_q[SYNC_STAGES-1];

  // TERI records only the trailing edge of ring
  always_comb begin
    set    = cur ^ prev;
    set[2] = prev[2] & ~cur[2];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prev      <= '0;
      delta     <= '0;
      rts_pad_o <= 1'b0;
      dtr_pad_o <= 1'b0;
    end else begin
      prev      <= cur;
      delta     <= (msr_rd ? 4'h0 : delta) | set;
      rts_pad_o <= mcr_rts & ~mcr_loop;
      dtr_pad_o <= mcr_dtr & ~mcr_loop;
    end
  end

  assign msr    = {cur, delta};
  assign ms_int = ms_int_en & (|delta);

endmodule

// File: tb/tb_modem_ctrl.sv
// Directed bench for modem_ctrl with a cycle model checked on every
// falling edge plus hand-computed MSR/pad/interrupt values.
module tb_modem_ctrl;

  localparam int SS = 2;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       mcr_dtr, mcr_rts, mcr_out1, mcr_out2, mcr_loop;
  logic       ms_int_en, msr_rd;
  logic       cts_pad_i, dsr_pad_i, ri_pad_i, dcd_pad_i;
  logic       rts_pad_o, dtr_pad_o, ms_int;
  logic [7:0] msr;

  int total = 0;
  int passed = 0;

  modem_ctrl #(.SYNC_STAGES(SS)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .mcr_dtr(mcr_dtr), .mcr_rts(mcr_rts),
    .mcr_out1(mcr_out1), .mcr_out2(mcr_out2),
    .mcr_loop(mcr_loop), .ms_int_en(ms_int_en),
    .msr_rd(msr_rd),
    .cts_pad_i(cts_pad_i), .dsr_pad_i(dsr_pad_i),
    .ri_pad_i(ri_pad_i), .dcd_pad_i(dcd_pad_i),
    .rts_pad_o(rts_pad_o), .dtr_pad_o(dtr_pad_o),
    .msr(msr), .ms_int(ms_int)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: pad samples delayed SS edges, flags from edge history
  logic [3:0] hist [SS];
  logic [3:0] m_prev, m_flags, m_cur, mb;
  logic       m_rts, m_dtr;

  function automatic logic [3:0] mcr_bits();
    return {mcr_out2, mcr_out1, mcr_dtr, mcr_rts};
  endfunction

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < SS; i++) hist[i] = '0;
      m_prev = '0; m_flags = '0; m_rts = 0; m_dtr = 0;
    end else begin
      mb = mcr_bits();
      m_cur = mcr_loop ? mb : hist[0];
      if (msr_rd) m_flags = '0;
      for (int b = 0; b < 4; b++) begin
        if (b == 2) begin
          if (m_prev[2] && !m_cur[2]) m_flags[2] = 1'b1;
        end else if (m_prev[b] != m_cur[b]) begin
          m_flags[b] = 1'b1;
        end
      end
      m_prev = m_cur;
      for (int i = 0; i < SS - 1; i++) hist[i] = hist[i+1];
      hist[SS-1] = {dcd_pad_i, ri_pad_i, dsr_pad_i, cts_pad_i};
      m_rts = mcr_rts && !mcr_loop;
      m_dtr = mcr_dtr && !mcr_loop;
    end
  end

  always @(negedge PCLK) begin
    logic [3:0] c;
    c = mcr_loop ? mcr_bits() : hist[0];
    chk("model_msr", msr, {c, m_flags});
    chk("model_int", {7'd0, ms_int}, {7'd0, ms_int_en && (m_flags != 0)});
    chk("model_rts", {7'd0, rts_pad_o}, {7'd0, m_rts});
    chk("model_dtr", {7'd0, dtr_pad_o}, {7'd0, m_dtr});
  end

  task automatic step(int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic set_pads(logic [3:0] p);
    {dcd_pad_i, ri_pad_i, dsr_pad_i, cts_pad_i} = p;
  endtask

  task automatic rd_pulse();
    msr_rd = 1; step(1); msr_rd = 0;
  endtask

  initial begin
    PRESETn = 0;
    mcr_dtr = 1; mcr_rts = 1; mcr_out1 = 0; mcr_out2 = 0;
    mcr_loop = 0; ms_int_en = 0; msr_rd = 0;
    set_pads(4'hF);
    step(3);
    chk("rst_msr", msr, 8'h00);
    chk("rst_rts", {7'd0, rts_pad_o}, 8'h00);
    chk("rst_dtr", {7'd0, dtr_pad_o}, 8'h00);
    chk("rst_int", {7'd0, ms_int}, 8'h00);
    PRESETn = 1;
    step(SS + 1);
    chk("post_rst_msr", msr, 8'hFB);
    chk("pads_on", {6'd0, rts_pad_o, dtr_pad_o}, 8'h03);

    rd_pulse();
    chk("rd_clear", msr, 8'hF0);
    set_pads(4'h0);
    step(4);
    chk("all_fall", msr, 8'h0F);
    rd_pulse();
    chk("rd_clear2", msr, 8'h00);

    ms_int_en = 1;
    cts_pad_i = 1;
    step(1);
    chk("cts_e1", msr, 8'h00);
    step(1);
    chk("cts_e2", msr, 8'h10);
    step(1);
    chk("cts_e3", msr, 8'h11);
    chk("cts_int", {7'd0, ms_int}, 8'h01);
    rd_pulse();
    chk("cts_rd", msr, 8'h10);
    chk("cts_int_clr", {7'd0, ms_int}, 8'h00);

    ri_pad_i = 1;
    step(3);
    chk("ri_rise", msr, 8'h50);
    ri_pad_i = 0;
    step(3);
    chk("ri_fall", msr, 8'h14);
    rd_pulse();
    chk("ri_rd", msr, 8'h10);

    dsr_pad_i = 1;
    step(2);
    chk("dsr_cur", msr, 8'h30);
    rd_pulse();
    chk("collision", msr, 8'h32);
    rd_pulse();
    chk("coll_rd", msr, 8'h30);

    mcr_loop = 1; mcr_rts = 1; mcr_out2 = 1;
    mcr_dtr = 0; mcr_out1 = 0;
    #1;
    chk("loop_comb", msr, 8'h90);
    step(1);
    chk("loop_pads", {6'd0, rts_pad_o, dtr_pad_o}, 8'h00);
    chk("loop_delta", msr, 8'h9A);
    rd_pulse();
    cts_pad_i = 0;
    step(3);
    chk("loop_cts_ign", msr, 8'h90);
    mcr_loop = 0;
    step(1);
    chk("loop_off", msr, 8'h2B);
    rd_pulse();
    chk("loop_off_rd", msr, 8'h20);

    ms_int_en = 0;
    dcd_pad_i = 1;
    step(3);
    chk("mask_msr", msr, 8'hA8);
    chk("mask_int", {7'd0, ms_int}, 8'h00);
    ms_int_en = 1;
    #1;
    chk("unmask_int", {7'd0, ms_int}, 8'h01);

    step(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
